// File: rtl/cabac_bina_bin_queue.sv
// ---------------------------------------------------------------------------
// cabac_bina_bin_queue
//
// Elastic bin-descriptor queue sitting between the CABAC binarizer and the
// bin arithmetic encoder (BAE). Up to DEPTH descriptors of BIN_W bits are
// held in one flat register with the head entry in the most significant
// slot. Each cycle up to WR_MAX bins may be appended and up to RD_MAX bins
// removed from the head. Both operations are done at once with two
// entry-granular barrel shifters:
//   - the surviving contents move towards the head by the number popped;
//   - the accepted new bins are placed just behind the survivors.
// A small RUN/DRAIN/DONE controller blocks new pushes at CTU end until the
// consumer has emptied the queue, then pulses done_o.
//
// Ports
//   clk        clock, everything on the rising edge
//   rst_n      synchronous active-low reset
//   wr_num_i   bins offered this cycle (0..4)
//   wr_data_i  offered bins, bin k at [35-9k -: 9], bin 0 oldest
//   wr_rdy_o   push of up to 4 bins is accepted this cycle
//   rd_num_i   bins the consumer takes this cycle (0..4)
//   rd_data_o  head 4 entries, entry k at [35-9k -: 9]
//   rd_cnt_o   number of valid entries (0..18)
//   flush_i    end-of-CTU drain request (pulse)
//   done_o     one-cycle pulse when the drain completes
//   err_o      sticky protocol-error flag
//
// Only the default parameter values are supported.
// ---------------------------------------------------------------------------
module cabac_bina_bin_queue #(
    parameter int BIN_W  = 9,
    parameter int DEPTH  = 18,
    parameter int WR_MAX = 4,
    parameter int RD_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               wr_num_i,
    input  logic [BIN_W*WR_MAX-1:0]  wr_data_i,
    output logic                     wr_rdy_o,
    input  logic [2:0]               rd_num_i,
    output logic [BIN_W*RD_MAX-1:0]  rd_data_o,
    output logic [4:0]               rd_cnt_o,
    input  logic                     flush_i,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int BUF_W   = BIN_W * DEPTH;
    localparam int WR_W    = BIN_W * WR_MAX;
    localparam int RD_W    = BIN_W * RD_MAX;
    // Five stages cover shift amounts 0..31 entries; only 0..18 occur.
    localparam int NSTAGE  = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [BUF_W-1:0]   buf_reg,   buf_next;
    logic [4:0]         cnt_reg,   cnt_next;
    logic               err_reg,   err_next;
    logic               done_reg;

    logic [2:0]         wr_lim;     // offered count clamped to WR_MAX
    logic [2:0]         rd_lim;     // requested pop clamped to RD_MAX
    logic [2:0]         acc_w;      // bins actually accepted
    logic [2:0]         eff_r;      // bins actually popped
    logic [4:0]         keep_cnt;   // entries surviving the pop
    logic               wr_rdy;

    // -----------------------------------------------------------------------
    // Handshake and count arithmetic
    // -----------------------------------------------------------------------
    assign wr_rdy = (state_reg == ST_RUN) && (cnt_reg <= 5'(DEPTH - WR_MAX));

    always_comb begin
        wr_lim = (wr_num_i > 3'(WR_MAX)) ? 3'(WR_MAX) : wr_num_i;
        rd_lim = (rd_num_i > 3'(RD_MAX)) ? 3'(RD_MAX) : rd_num_i;
        acc_w  = wr_rdy ? wr_lim : 3'd0;
        // cnt_reg is below rd_lim (<= 4) here, so its low bits hold it.
        if ({2'b00, rd_lim} > cnt_reg) begin
            eff_r = cnt_reg[2:0];
        end else begin
            eff_r = rd_lim;
        end
        keep_cnt = cnt_reg - {2'b00, eff_r};
        cnt_next = keep_cnt + {2'b00, acc_w};
    end

    // Protocol errors: push while blocked, oversized push, over-pop.
    always_comb begin
        err_next = err_reg;
        if ((wr_num_i != 3'd0) && !wr_rdy) begin
            err_next = 1'b1;
        end
        if (wr_num_i > 3'(WR_MAX)) begin
            err_next = 1'b1;
        end
        if (({2'b00, rd_num_i} > cnt_reg) || (rd_num_i > 3'(RD_MAX))) begin
            err_next = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Pop compaction: shift contents towards the head by eff_r entries.
    // Zero fill keeps every slot at index >= cnt cleared.
    // -----------------------------------------------------------------------
    logic [NSTAGE:0][BUF_W-1:0] lsh;
    logic [4:0]                 lsh_amt;

    assign lsh_amt = {2'b00, eff_r};
    assign lsh[0]  = buf_reg;

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_lsh
            assign lsh[gi+1] = lsh_amt[gi] ? (lsh[gi] << (BIN_W * (1 << gi)))
                                           : lsh[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Push alignment: unaccepted slots are masked so the OR below cannot
    // inject stale data, then the block is moved behind the survivors.
    // -----------------------------------------------------------------------
    logic [WR_W-1:0]            wr_masked;
    logic [NSTAGE:0][BUF_W-1:0] rsh;

    generate
        for (genvar gi = 0; gi < WR_MAX; gi++) begin : g_mask
            assign wr_masked[WR_W-1-BIN_W*gi -: BIN_W] =
                (acc_w > 3'(gi)) ? wr_data_i[WR_W-1-BIN_W*gi -: BIN_W]
                                 : {BIN_W{1'b0}};
        end
    endgenerate

    assign rsh[0] = {wr_masked, {(BUF_W-WR_W){1'b0}}};

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_rsh
            assign rsh[gi+1] = keep_cnt[gi] ? (rsh[gi] >> (BIN_W * (1 << gi)))
                                            : rsh[gi];
        end
    endgenerate

    assign buf_next = lsh[NSTAGE] | rsh[NSTAGE];

    // -----------------------------------------------------------------------
    // Drain controller next state. DRAIN waits on the registered count so an
    // empty queue at flush time still spends one cycle in DRAIN.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:   if (flush_i) state_next = ST_DRAIN;
            ST_DRAIN: if (cnt_reg == 5'd0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            buf_reg   <= '0;
            cnt_reg   <= 5'd0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            // Registered so that done_o is high exactly while in DONE.
            done_reg  <= (state_next == ST_DONE);
        end
    end

    assign wr_rdy_o  = wr_rdy;
    assign rd_data_o = buf_reg[BUF_W-1 -: RD_W];
    assign rd_cnt_o  = cnt_reg;
    assign done_o    = done_reg;
    assign err_o     = err_reg;

endmodule

// File: doc/cabac_bina_bin_queue.md
Name: cabac_bina_bin_queue

Overview:
- Elastic bin-descriptor queue between the CABAC binarizer and the bin arithmetic encoder (BAE).
- Holds up to 18 entries of 9 bits each in a 162-bit register, with entry 0 (head) at bits 161:153.
- Each cycle it can accept up to 4 bins from the binarizer and release up to 4 bins to the BAE.
- Compaction after a pop, and alignment of pushed bins, are done with 9-bit-granular barrel shifts. A flush FSM drains the queue at CTU end.

Parameters:
- BIN_W, 9: bits per bin descriptor. The format is opaque to this block.
- DEPTH, 18: entry capacity. Buffer width is BIN_W*DEPTH = 162.
- WR_MAX, 4: maximum bins pushed per cycle.
- RD_MAX, 4: maximum bins popped per cycle.
- Only the default values are supported.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_num_i  in  3  number of bins offered this cycle, 0..4.
- wr_data_i  in  36  offered bins; bin k sits at [35-9k -: 9], bin 0 is the oldest.
- wr_rdy_o  out  1  high when a push of up to 4 bins is accepted this cycle.
- rd_num_i  in  3  number of bins the consumer takes this cycle, 0..4.
- rd_data_o  out  36  head 4 entries; entry k at [35-9k -: 9].
- rd_cnt_o  out  5  number of valid entries, 0..18.
- flush_i  in  1  end-of-CTU drain request, single-cycle pulse.
- done_o  out  1  one-cycle pulse when the drain completes.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - buffer=0, cnt=0, state=RUN, err_o=0, done_o=0.
  - rd_data_o=0, rd_cnt_o=0, wr_rdy_o=1 in the following cycle.
  - Reset mid-operation discards all contents with no drain.
- wr_rdy_o = (state==RUN) && (cnt <= DEPTH-WR_MAX, i.e. cnt <= 14). It is combinational from registered state.
- Accepted push: acc_w = wr_rdy_o ? min(wr_num_i,4) : 0.
- Effective pop: eff_r = min(rd_num_i, 4, cnt).
- Next count: cnt_next = cnt - eff_r + acc_w. This never exceeds 18 and never goes below 0.
- Buffer update, all in one cycle:
  1. shifted = buffer left-shifted by 9*eff_r, zero-filled.
  2. newbins = {wr_data_i, 126'b0}, with slots ≥ acc_w masked to 0, right-shifted by 9*(cnt-eff_r).
  3. buffer_next = shifted | newbins.
- Invariant: entries at index ≥ cnt are always zero.
- Both shifts use 5-bit unit amounts in 9-bit steps. Shift amounts stay ≤ 18 units.
- rd_data_o = buffer[161:126], rd_cnt_o = cnt. Both are driven straight from registers.
- Latency: a bin pushed in cycle t is visible on rd_data_o in cycle t+1. Pop and push in the same cycle are fully concurrent.
- Error conditions set err_o on the next edge; it stays 1 until reset:
  - wr_num_i != 0 while wr_rdy_o=0. The bins are dropped.
  - wr_num_i > 4. The push is clamped to 4.
  - rd_num_i > cnt. The pop is clamped to cnt.
  - rd_num_i > 4. The pop is clamped to 4.
- FSM states RUN, DRAIN, DONE:
  - RUN: flush_i=1 → DRAIN. A push presented in the same cycle as flush_i is still accepted.
  - DRAIN: wr_rdy_o=0; pops continue. When registered cnt==0 → DONE. With an empty queue at flush time, DONE is reached 2 cycles after flush_i.
  - DONE: done_o=1 for exactly this one cycle; → RUN unconditionally. wr_rdy_o=0 in DONE.
  - flush_i in DRAIN or DONE is ignored and is not an error.
  - done_o is a registered decode of state==DONE.

Test Plan:
1. Single push:
   - Stimulus: reset, then cycle 0 wr_num_i=4, data {0x101,0x102,0x103,0x104}.
   - Response: cycle 1 rd_cnt_o=4, rd_data_o={0x101,0x102,0x103,0x104}, wr_rdy_o=1.
2. Fill and backpressure:
   - Stimulus: 4 pushes per cycle, no pops.
   - Response: cnt goes 4, 8, 12, 16; wr_rdy_o=0 at cnt=16.
   - Stimulus: further wr_num_i=4 while not ready.
   - Response: cnt stays 16, err_o=1.
   - Stimulus: after reset, repeat the fill, then pop 2.
   - Response: cnt=14, wr_rdy_o=1 in the next cycle.
3. Simultaneous pop and push:
   - Stimulus: queue {A,B,C} (cnt=3); rd_num_i=2 with wr_num_i=3 {D,E,F}.
   - Response: next cycle cnt=4, rd_data_o={C,D,E,F}; entries 4..17 are zero.
4. Flush drain:
   - Stimulus: cnt=6, flush_i pulse; pops of 4 then 2.
   - Response: wr_rdy_o=0 from the cycle after the flush; cnt 6→2→0; done_o high for exactly one cycle after cnt reaches 0; then state RUN and wr_rdy_o=1.
5. Pop underflow:
   - Stimulus: cnt=1, rd_num_i=3.
   - Response: cnt=0, rd_data_o=0, err_o=1, held through later legal traffic.
6. Reset mid-drain:
   - Stimulus: cnt=10 in DRAIN, rst_n=0 for one edge.
   - Response: cnt=0, err_o=0, done_o never pulses, wr_rdy_o=1.
